// File: rtl/otter_pkg.sv
// Shared OTTER core types: datapath width, instruction encodings and the fetch-queue entry.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_t    opcode;
    } instr_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect request and decode-side handshake.
interface otter_fetch_queue_if
    import otter_pkg::*;
#(
    parameter int W     = otter_pkg::XLEN,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_rd;
    logic [W-1:0]  imem_addr;
    logic [W-1:0]  imem_data;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_ir;
    logic [CW-1:0] count;

    modport master (
        output imem_rd, imem_addr, out_valid, out_pc, out_ir, count,
        input  imem_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, out_pc, out_ir, count,
        output imem_data, redirect, redirect_pc, out_ready
    );

endinterface

// File: rtl/otter_sync_fifo.sv
// Circular-buffer FIFO of arbitrary element type with synchronous flush; storage is not reset.
module otter_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  T                       wr_data,
    input  logic                   rd_en,
    output T                       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    T mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_rd    = rd_en & (count_q != '0);
        do_wr    = wr_en & ~flush & ((count_q != FULL) | do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + {{PW{1'b0}}, do_wr} - {{PW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER instruction fetch: issues sequential reads, queues {pc, ir} for decode, flushes on redirect.
module otter_fetch_queue
    import otter_pkg::*;
#(
    parameter int              XLEN     = otter_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    otter_fetch_queue_if.master bus
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            issue, enq, deq, head_valid;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     committed;
    fetch_entry_t    wr_entry, head_entry;

    // A slot is reserved for the outstanding read so its response can never find the queue full.
    always_comb begin
        head_valid    = (fifo_count != '0);
        deq           = head_valid & bus.out_ready & ~bus.redirect;
        enq           = inflight_q & ~bus.redirect;
        committed     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};
        issue         = ~RESET & ~bus.redirect & (committed < DEPTH_W);
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (bus.redirect) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
            inflight_pc_d = fetch_pc_q;
        end
        wr_entry.pc = inflight_pc_q;
        wr_entry.ir = bus.imem_data;
    end

    // Clearing inflight on reset/redirect is what drops a response already on its way back.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge CLK) begin
        inflight_pc_q <= inflight_pc_d;
    end

    otter_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .flush   (bus.redirect),
        .wr_en   (enq),
        .wr_data (wr_entry),
        .rd_en   (deq),
        .rd_data (head_entry),
        .count   (fifo_count)
    );

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_entry.pc;
    assign bus.out_ir    = head_entry.ir;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed vector table on a DEPTH=4 queue plus scoreboarded random-ready runs on DEPTH=2 and DEPTH=8.
module tb_otter_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;

    otter_fetch_queue_if #(.DEPTH(4)) m_if ();
    otter_fetch_queue_if #(.DEPTH(2)) r2_if ();
    otter_fetch_queue_if #(.DEPTH(8)) r8_if ();

    otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut_m  (.CLK(clk), .RESET(rst), .bus(m_if.master));
    otter_fetch_queue #(.DEPTH(2), .RESET_PC(32'h0)) dut_r2 (.CLK(clk), .RESET(rst), .bus(r2_if.master));
    otter_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut_r8 (.CLK(clk), .RESET(rst), .bus(r8_if.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory models: word returned one cycle after the read strobe.
    always @(posedge clk) m_if.imem_data  <= m_if.imem_rd  ? (m_if.imem_addr  ^ KEY) : 32'hBAD0_BAD0;
    always @(posedge clk) r2_if.imem_data <= r2_if.imem_rd ? (r2_if.imem_addr ^ KEY) : 32'hBAD0_BAD0;
    always @(posedge clk) r8_if.imem_data <= r8_if.imem_rd ? (r8_if.imem_addr ^ KEY) : 32'hBAD0_BAD0;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        full;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd_in, input logic [31:0] rpc,
                                input logic full, input logic e_rd, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_count);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rd_in; v.rpc = rpc;
        v.full = full; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_count = e_count;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        m_if.out_ready   = v.ready;
        m_if.redirect    = v.redir;
        m_if.redirect_pc = v.rpc;
        #1;
    endtask

    // Scoreboard state for the random runs: index 0 is DEPTH=2, index 1 is DEPTH=8.
    int          m_cnt   [2];
    bit          m_infl  [2];
    logic [31:0] m_fetch [2];
    logic [31:0] m_next  [2];
    int          m_depth [2];

    task automatic rand_check(input int idx, input int cyc, input logic ready, input logic rd,
                              input logic [31:0] addr, input logic valid, input logic [31:0] pc,
                              input logic [31:0] ir, input logic [31:0] cnt);
        bit deq;
        bit exp_rd;
        deq    = (m_cnt[idx] != 0) && ready;
        exp_rd = (m_cnt[idx] + int'(m_infl[idx]) - int'(deq)) < m_depth[idx];
        check_output($sformatf("d%0d c%0d imem_rd", m_depth[idx], cyc), {31'b0, rd}, {31'b0, exp_rd});
        check_output($sformatf("d%0d c%0d imem_addr", m_depth[idx], cyc), addr, m_fetch[idx]);
        check_output($sformatf("d%0d c%0d out_valid", m_depth[idx], cyc), {31'b0, valid}, {31'b0, m_cnt[idx] != 0});
        check_output($sformatf("d%0d c%0d count", m_depth[idx], cyc), cnt, 32'(m_cnt[idx]));
        if (deq) begin
            check_output($sformatf("d%0d c%0d out_pc", m_depth[idx], cyc), pc, m_next[idx]);
            check_output($sformatf("d%0d c%0d out_ir", m_depth[idx], cyc), ir, m_next[idx] ^ KEY);
        end
        m_cnt[idx]  = m_cnt[idx] + int'(m_infl[idx]) - int'(deq);
        m_infl[idx] = exp_rd;
        if (exp_rd) m_fetch[idx] = m_fetch[idx] + 32'd4;
        if (deq)    m_next[idx]  = m_next[idx] + 32'd4;
    endtask

    initial begin
        rst = 1'b1;
        m_if.out_ready = 1'b0;  m_if.redirect = 1'b0;  m_if.redirect_pc = '0;
        r2_if.out_ready = 1'b0; r2_if.redirect = 1'b0; r2_if.redirect_pc = '0;
        r8_if.out_ready = 1'b0; r8_if.redirect = 1'b0; r8_if.redirect_pc = '0;

        // Streaming from reset with out_ready=1.
        vecs.push_back(mk(1,1,0,0,        0, 0,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(1,1,0,0,        1, 0,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h4,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h8,   1,32'h0,  1));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'hC,   1,32'h4,  1));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h10,  1,32'h8,  1));
        // Fill with out_ready=0, then drain; issue resumes with the first dequeue.
        vecs.push_back(mk(1,0,0,0,        0, 0,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(1,0,0,0,        1, 0,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,0,0,0,        1, 1,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,0,0,0,        1, 1,32'h4,   0,32'h0,  0));
        vecs.push_back(mk(0,0,0,0,        1, 1,32'h8,   1,32'h0,  1));
        vecs.push_back(mk(0,0,0,0,        1, 1,32'hC,   1,32'h0,  2));
        vecs.push_back(mk(0,0,0,0,        1, 0,32'h10,  1,32'h0,  3));
        vecs.push_back(mk(0,0,0,0,        1, 0,32'h10,  1,32'h0,  4));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h10,  1,32'h0,  4));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h14,  1,32'h4,  3));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h18,  1,32'h8,  3));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h1C,  1,32'hC,  3));
        // Redirect with count=3 and a read in flight; target is word-aligned.
        vecs.push_back(mk(0,1,1,32'h103,  1, 0,32'h20,  1,32'h10, 3));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h100, 0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h104, 0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h108, 1,32'h100,1));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h10C, 1,32'h104,1));
        // Back-to-back redirects: last one wins.
        vecs.push_back(mk(0,1,1,32'h200,  1, 0,32'h110, 1,32'h108,1));
        vecs.push_back(mk(0,1,1,32'h300,  1, 0,32'h200, 0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h300, 0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h304, 0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h308, 1,32'h300,1));
        // Reset mid-stream with a read in flight.
        vecs.push_back(mk(1,1,0,0,        0, 0,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h0,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h4,   0,32'h0,  0));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'h8,   1,32'h0,  1));
        vecs.push_back(mk(0,1,0,0,        1, 1,32'hC,   1,32'h4,  1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d imem_rd", i), {31'b0, m_if.imem_rd}, {31'b0, vecs[i].e_rd});
            if (vecs[i].full) begin
                check_output($sformatf("v%0d imem_addr", i), m_if.imem_addr, vecs[i].e_addr);
                check_output($sformatf("v%0d out_valid", i), {31'b0, m_if.out_valid}, {31'b0, vecs[i].e_valid});
                check_output($sformatf("v%0d count", i), {29'b0, m_if.count}, vecs[i].e_count);
                if (vecs[i].e_valid) begin
                    check_output($sformatf("v%0d out_pc", i), m_if.out_pc, vecs[i].e_pc);
                    check_output($sformatf("v%0d out_ir", i), m_if.out_ir, vecs[i].e_pc ^ KEY);
                end
            end
        end

        // Random out_ready on DEPTH=2 and DEPTH=8, started just below the 32-bit wrap point.
        @(negedge clk);
        r2_if.redirect = 1'b1; r2_if.redirect_pc = 32'hFFFF_FFE0; r2_if.out_ready = 1'b1;
        r8_if.redirect = 1'b1; r8_if.redirect_pc = 32'hFFFF_FFE0; r8_if.out_ready = 1'b1;
        #1;
        check_output("d2 redirect imem_rd", {31'b0, r2_if.imem_rd}, 32'd0);
        check_output("d8 redirect imem_rd", {31'b0, r8_if.imem_rd}, 32'd0);
        m_depth[0] = 2; m_depth[1] = 8;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_infl[k] = 1'b0;
            m_fetch[k] = 32'hFFFF_FFE0; m_next[k] = 32'hFFFF_FFE0;
        end
        @(negedge clk);
        r2_if.redirect = 1'b0;
        r8_if.redirect = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clk);
            r2_if.out_ready = 1'($urandom_range(1, 0));
            r8_if.out_ready = 1'($urandom_range(1, 0));
            #1;
            rand_check(0, c, r2_if.out_ready, r2_if.imem_rd, r2_if.imem_addr, r2_if.out_valid,
                       r2_if.out_pc, r2_if.out_ir, {30'b0, r2_if.count});
            rand_check(1, c, r8_if.out_ready, r8_if.imem_rd, r8_if.imem_addr, r8_if.out_valid,
                       r8_if.out_pc, r8_if.out_ir, {28'b0, r8_if.count});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/otter_fetch_queue.md
OTTER_FETCH_QUEUE -- requirements
Module: otter_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter XLEN, default 32, address and instruction width.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 imem_rd  out  1  instruction-memory read enable (issue strobe).
REQ-007 imem_addr  out  XLEN  fetch address, valid when imem_rd=1.
REQ-008 imem_data  in  XLEN  instruction word, valid exactly one cycle after the issuing imem_rd.
REQ-009 redirect  in  1  one-cycle flush/redirect request from EX (branch, jump or trap).
REQ-010 redirect_pc  in  XLEN  new fetch address, sampled when redirect=1.
REQ-011 out_valid  out  1  head entry available to decode.
REQ-012 out_ready  in  1  decode accepts head; the entry is consumed when out_valid & out_ready.
REQ-013 out_pc  out  XLEN  PC of head entry.
REQ-014 out_ir  out  XLEN  instruction of head entry.
REQ-015 count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 fetch_pc register holds next fetch address; imem_addr = fetch_pc.
REQ-017 Issue: imem_rd=1 iff !RESET & !redirect & (count + inflight - deq) < DEPTH, where deq = out_valid & out_ready and inflight = an outstanding read.
REQ-018 On issue: fetch_pc <= fetch_pc + 4 (mod 2^XLEN, wrap silent), inflight <= 1, inflight_pc <= fetch_pc.
REQ-019 Cycle after issue: unless flushed, {inflight_pc, imem_data} is written at the tail; inflight clears unless a new issue occurs in that cycle.
REQ-020 No bypass: an entry written at the end of cycle N is presented with out_valid=1 in cycle N+1; issue-to-out_valid latency is 2 cycles.
REQ-021 out_valid = (count != 0); out_pc/out_ir come from the head entry and are stable while out_valid & !out_ready.
REQ-022 Simultaneous enqueue and dequeue leaves count unchanged; enqueue is never lost when full because of the REQ-017 reservation.
REQ-023 Sustained throughput is one instruction per cycle with out_ready held 1 for any DEPTH >= 2.
REQ-024 Head/tail pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows; dequeue with count=0 is impossible.
REQ-025 Redirect (highest priority): queue emptied (count<=0, pointers<=0), the in-flight response arriving next cycle is discarded, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, imem_rd=0 in the redirect cycle.
REQ-026 A handshake in the redirect cycle is void; the head entry is discarded with the rest.
REQ-027 The first issue after redirect occurs in the next cycle from redirect_pc; out_valid returns no earlier than 3 cycles after redirect.
REQ-028 Back-to-back redirects: the last one wins; each one discards any response still pending.

Reset
REQ-029 While RESET=1: imem_rd=0, out_valid=0, count=0, pointers=0, inflight=0, fetch_pc=RESET_PC.
REQ-030 A response arriving in the first cycle after RESET deasserts (issued before reset) is discarded.
REQ-031 The first issue is in the first cycle with RESET=0, at address RESET_PC.
REQ-032 Queue storage contents need no reset; only the control state is reset.

Structure
REQ-033 Shared package otter_pkg holds XLEN, fetch_entry_t (packed {pc, ir}) and the existing opcode_t/instr_t typedefs.
REQ-034 Storage is one sub-module, otter_sync_fifo (parameters DEPTH and element type, with synchronous flush input); fetch/issue control stays in otter_fetch_queue.

Verification
REQ-035 Reset release, out_ready=1, imem_data=addr^32'hA5A5_A5A5 -> imem_addr 0,4,8,... on consecutive cycles; first out_valid 2 cycles after first issue with out_pc=0; one output per cycle thereafter.
REQ-036 DEPTH=4, out_ready=0 -> exactly 4 issues then imem_rd=0, count=4; raise out_ready -> entries in order PC 0,4,8,12, and issue resumes in the same cycle as the first dequeue.
REQ-037 redirect=1, redirect_pc=32'h0000_0103 while count=3 and a read is in flight -> next cycle count=0, out_valid=0, imem_addr=32'h100; stale response not enqueued; out_pc=32'h100 is the first valid 3 cycles after redirect.
REQ-038 Redirect in two consecutive cycles (targets 0x200, then 0x300) -> no 0x200 entry ever reaches out_valid; first output PC is 0x300.
REQ-039 Random out_ready (50%), DEPTH=2 and 8 -> scoreboard: output PCs strictly sequential, no loss or duplication, count matches the model, fetch_pc wraps from 0xFFFF_FFFC to 0.
REQ-040 RESET asserted mid-stream with a read in flight -> outputs per REQ-029 next cycle; post-reset first output PC=RESET_PC, stale data never observed.
